// File: rtl/i2c_apb_pkg.sv
// Shared constants for the APB-to-I2C register block: register offsets,
// CTRL/STATUS bit positions and the byte-sequencer state encoding.
package i2c_apb_pkg;

    localparam int CTRL_OFF   = 'h00;
    localparam int ADDR_OFF   = 'h04;
    localparam int TXDATA_OFF = 'h08;
    localparam int STATUS_OFF = 'h0C;
    localparam int RXDATA_OFF = 'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RW     = 1;
    localparam int CTRL_START  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_BUSY     = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_VALID = 3;
    localparam int ST_NACK     = 4;
    localparam int ST_CNT_LO   = 5;
    localparam int ST_CNT_HI   = 7;
    localparam int ST_DONE     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } state_e;

endpackage

// File: rtl/apb_i2c_regs_if.sv
// APB3 bus bundle between a bus master and the I2C register block.
interface apb_i2c_regs_if #(
    parameter int AW = 5
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/i2c_tx_fifo.sv
// Small synchronous TX byte FIFO. Push is refused when full (judged before
// any same-cycle pop), pop is refused when empty, flush empties it.
module i2c_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int W          = 8,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointer/count values; flush overrides any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/apb_i2c_regs.sv
// APB3 register front-end for i2c_core: CTRL/ADDR/TXDATA/STATUS/RXDATA,
// a TX byte FIFO and a sequencer feeding the core one byte at a time.
// Optional interrupt output enabled by defining I2C_APB_IRQ_EN.
module apb_i2c_regs
    import i2c_apb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 5
) (
    input  logic       clk,
    input  logic       rst,
    apb_i2c_regs_if.slave apb,
    output logic       enable,
    output logic [6:0] slave_address,
    output logic [7:0] data_in,
    output logic       rw,
    input  logic       core_done,
    input  logic       core_nack,
    input  logic [7:0] core_rx_data
`ifdef I2C_APB_IRQ_EN
    ,
    output logic       irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q;
    logic          enable_q, rw_q;
    logic [6:0]    slave_address_q;
    logic [7:0]    data_in_q;
    logic          ctrl_en_q, ctrl_en_d, ctrl_rw_q, ctrl_rw_d;
    logic [6:0]    addr_q, addr_d;
    logic          nack_q, nack_d, rxv_q, rxv_d;
    logic [7:0]    rxd_q, rxd_d;
    logic          fifo_full, fifo_empty, push, pop, flush;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic [31:0]   rdata;
    logic          acc, wr, rd, sel_ctrl, sel_addr, sel_tx, sel_status, sel_rx;
    logic          busy, abort, start, byte_done, more, nack_set, rx_set, done_set;
`ifdef I2C_APB_IRQ_EN
    logic          irq_en_q, irq_en_d, done_q, done_d, irq_q;
    logic          unused_pwdata;
    assign unused_pwdata = ^apb.pwdata[31:9];
`else
    logic          unused_pwdata;
    assign unused_pwdata = ^{apb.pwdata[31:8], done_set};
`endif

    assign acc        = apb.psel & apb.penable;
    assign wr         = acc & apb.pwrite;
    assign rd         = acc & ~apb.pwrite;
    assign sel_ctrl   = (apb.paddr == AW'(CTRL_OFF));
    assign sel_addr   = (apb.paddr == AW'(ADDR_OFF));
    assign sel_tx     = (apb.paddr == AW'(TXDATA_OFF));
    assign sel_status = (apb.paddr == AW'(STATUS_OFF));
    assign sel_rx     = (apb.paddr == AW'(RXDATA_OFF));

    assign apb.pready  = 1'b1;
    assign apb.pslverr = acc & (~(sel_ctrl | sel_addr | sel_tx | sel_status | sel_rx)
                                | (apb.pwrite & sel_tx & fifo_full));

    // Sequencer events. Clearing EN outranks a same-cycle core_done.
    assign busy      = (state_q != IDLE);
    assign abort     = busy & ~ctrl_en_q;
    assign start     = wr & sel_ctrl & (state_q == IDLE) & apb.pwdata[CTRL_EN]
                       & apb.pwdata[CTRL_START] & (apb.pwdata[CTRL_RW] | ~fifo_empty);
    assign byte_done = (state_q == XFER) & ctrl_en_q & core_done;
    assign more      = ~rw_q & ~fifo_empty;
    assign nack_set  = byte_done & core_nack;
    assign rx_set    = byte_done & ~core_nack & rw_q;
    assign done_set  = byte_done & (core_nack | ~more);
    assign push      = wr & sel_tx & ~fifo_full;
    assign pop       = (state_q == LOAD) & ctrl_en_q & ~ctrl_rw_q & ~fifo_empty;
    assign flush     = abort | nack_set;

    i2c_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (apb.pwdata[7:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Software-visible register updates; hardware set events win over clears.
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        ctrl_rw_d = ctrl_rw_q;
        addr_d    = addr_q;
        nack_d    = nack_q;
        rxv_d     = rxv_q;
        rxd_d     = rxd_q;
`ifdef I2C_APB_IRQ_EN
        irq_en_d  = irq_en_q;
        done_d    = done_q;
`endif
        if (wr && sel_ctrl) begin
            ctrl_en_d = apb.pwdata[CTRL_EN];
            ctrl_rw_d = apb.pwdata[CTRL_RW];
`ifdef I2C_APB_IRQ_EN
            irq_en_d  = apb.pwdata[CTRL_IRQ_EN];
`endif
        end
        if (wr && sel_addr) addr_d = apb.pwdata[6:0];
        if (wr && sel_status) begin
            if (apb.pwdata[ST_NACK]) nack_d = 1'b0;
`ifdef I2C_APB_IRQ_EN
            if (apb.pwdata[ST_DONE]) done_d = 1'b0;
`endif
        end
        if (rd && sel_rx) rxv_d = 1'b0;
        if (nack_set) nack_d = 1'b1;
        if (rx_set) begin
            rxv_d = 1'b1;
            rxd_d = core_rx_data;
        end
`ifdef I2C_APB_IRQ_EN
        if (done_set) done_d = 1'b1;
`endif
    end

    // Register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q <= 1'b0;
            ctrl_rw_q <= 1'b0;
            addr_q    <= '0;
            nack_q    <= 1'b0;
            rxv_q     <= 1'b0;
            rxd_q     <= '0;
`ifdef I2C_APB_IRQ_EN
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            ctrl_en_q <= ctrl_en_d;
            ctrl_rw_q <= ctrl_rw_d;
            addr_q    <= addr_d;
            nack_q    <= nack_d;
            rxv_q     <= rxv_d;
            rxd_q     <= rxd_d;
`ifdef I2C_APB_IRQ_EN
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            irq_q     <= irq_en_d & (done_d | nack_d | rxv_d);
`endif
        end
    end

    // Byte sequencer with registered core-side outputs; LOAD is the one
    // cycle where enable is low between consecutive bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            enable_q        <= 1'b0;
            slave_address_q <= '0;
            data_in_q       <= '0;
            rw_q            <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= LOAD;
                LOAD: begin
                    if (!ctrl_en_q) begin
                        state_q <= IDLE;
                    end else begin
                        slave_address_q <= addr_q;
                        rw_q            <= ctrl_rw_q;
                        if (!ctrl_rw_q) data_in_q <= fifo_head;
                        enable_q        <= 1'b1;
                        state_q         <= XFER;
                    end
                end
                XFER: begin
                    if (!ctrl_en_q) begin
                        enable_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (core_done) begin
                        enable_q <= 1'b0;
                        state_q  <= (!core_nack && more) ? LOAD : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read mux; unused fields read as zero.
    always_comb begin
        rdata = '0;
        if (sel_ctrl) begin
            rdata[CTRL_EN] = ctrl_en_q;
            rdata[CTRL_RW] = ctrl_rw_q;
`ifdef I2C_APB_IRQ_EN
            rdata[CTRL_IRQ_EN] = irq_en_q;
`endif
        end
        if (sel_addr) rdata[6:0] = addr_q;
        if (sel_status) begin
            rdata[ST_BUSY]              = busy;
            rdata[ST_TX_FULL]           = fifo_full;
            rdata[ST_TX_EMPTY]          = fifo_empty;
            rdata[ST_RX_VALID]          = rxv_q;
            rdata[ST_NACK]              = nack_q;
            rdata[ST_CNT_HI:ST_CNT_LO]  = 3'(fifo_count);
`ifdef I2C_APB_IRQ_EN
            rdata[ST_DONE]              = done_q;
`endif
        end
        if (sel_rx) rdata[7:0] = rxd_q;
    end

    assign apb.prdata    = rd ? rdata : '0;
    assign enable        = enable_q;
    assign slave_address = slave_address_q;
    assign data_in       = data_in_q;
    assign rw            = rw_q;
`ifdef I2C_APB_IRQ_EN
    assign irq           = irq_q;
`endif
endmodule

// File: tb/tb_apb_i2c_regs.sv
// Scoreboard bench for apb_i2c_regs: APB stimulus pushes expected responses
// from a queue-based register model; a monitor compares on each access phase
// and on each new byte presented to the core.
module tb_apb_i2c_regs;
    import i2c_apb_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, rw, core_done, core_nack;
    logic [6:0] slave_address;
    logic [7:0] data_in, core_rx_data;
`ifdef I2C_APB_IRQ_EN
    logic       irq;
`endif

    always #5 clk = ~clk;

    apb_i2c_regs_if #(.AW(5)) apb ();

    apb_i2c_regs #(.FIFO_DEPTH(DEPTH), .AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .apb           (apb),
        .enable        (enable),
        .slave_address (slave_address),
        .data_in       (data_in),
        .rw            (rw),
        .core_done     (core_done),
        .core_nack     (core_nack),
        .core_rx_data  (core_rx_data)
`ifdef I2C_APB_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_en, m_rw, m_irqen, m_busy, m_nack, m_done, m_rxv;
    logic [6:0] m_addr;
    logic [7:0] m_rxd;
    logic [7:0] mq[$];

    // Scoreboard of expected APB responses
    logic [31:0] sb_data[$];
    bit          sb_chk[$];
    bit          sb_err[$];
    string       sb_name[$];

    bit en_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit mapped(input logic [4:0] a);
        return (a == 5'(CTRL_OFF)) || (a == 5'(ADDR_OFF)) || (a == 5'(TXDATA_OFF)) ||
               (a == 5'(STATUS_OFF)) || (a == 5'(RXDATA_OFF));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a == 5'(CTRL_OFF)) begin
            r[0] = m_en;
            r[1] = m_rw;
`ifdef I2C_APB_IRQ_EN
            r[3] = m_irqen;
`endif
        end else if (a == 5'(ADDR_OFF)) begin
            r[6:0] = m_addr;
        end else if (a == 5'(STATUS_OFF)) begin
            r[0]   = m_busy;
            r[1]   = (mq.size() == DEPTH);
            r[2]   = (mq.size() == 0);
            r[3]   = m_rxv;
            r[4]   = m_nack;
            r[7:5] = 3'(mq.size());
`ifdef I2C_APB_IRQ_EN
            r[8]   = m_done;
`endif
        end else if (a == 5'(RXDATA_OFF)) begin
            r[7:0] = m_rxd;
        end
        return r;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'(CTRL_OFF)) begin
            m_en = d[0];
            m_rw = d[1];
`ifdef I2C_APB_IRQ_EN
            m_irqen = d[3];
`endif
            if (!m_busy && d[2] && d[0] && (d[1] || mq.size() > 0)) m_busy = 1'b1;
            else if (m_busy && !d[0]) begin
                m_busy = 1'b0;
                mq.delete();
            end
        end else if (a == 5'(ADDR_OFF)) begin
            m_addr = d[6:0];
        end else if (a == 5'(TXDATA_OFF)) begin
            if (mq.size() < DEPTH) mq.push_back(d[7:0]);
        end else if (a == 5'(STATUS_OFF)) begin
            if (d[4]) m_nack = 1'b0;
`ifdef I2C_APB_IRQ_EN
            if (d[8]) m_done = 1'b0;
`endif
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_rw = 0; m_irqen = 0; m_busy = 0; m_nack = 0; m_done = 0; m_rxv = 0;
        m_addr = '0; m_rxd = '0;
        mq.delete();
    endtask

    task automatic check_irq();
`ifdef I2C_APB_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irqen & (m_done | m_nack | m_rxv)));
`endif
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, input string nm);
        sb_data.push_back(32'h0);
        sb_chk.push_back(1'b0);
        sb_err.push_back(!mapped(a) || (a == 5'(TXDATA_OFF) && mq.size() == DEPTH));
        sb_name.push_back(nm);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk);
        if (mapped(a)) model_write(a, d);
        #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
        check_irq();
    endtask

    task automatic apb_read(input logic [4:0] a, input string nm);
        sb_data.push_back(model_read(a));
        sb_chk.push_back(mapped(a));
        sb_err.push_back(!mapped(a));
        sb_name.push_back(nm);
        @(posedge clk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk);
        if (a == 5'(RXDATA_OFF)) m_rxv = 1'b0;
        #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
        check_irq();
    endtask

    task automatic wait_en(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!enable && n < 50);
        if (!enable) begin
            checks++; errors++;
            $display("FAIL %s: enable never rose within 50 cycles", nm);
        end
    endtask

    // Model reaction to the core finishing a byte.
    task automatic model_core_done(input bit nack, input logic [7:0] rx);
        if (nack) begin
            m_nack = 1'b1;
            mq.delete();
            m_busy = 1'b0;
            m_done = 1'b1;
        end else if (!m_rw && mq.size() > 0) begin
            m_busy = 1'b1;
        end else begin
            if (m_rw) begin
                m_rxv = 1'b1;
                m_rxd = rx;
            end
            m_busy = 1'b0;
            m_done = 1'b1;
        end
    endtask

    task automatic core_respond(input bit nack, input logic [7:0] rx, input int dly);
        if (!enable) wait_en("core wait enable");
        if (!enable) begin
            m_busy = 1'b0;
            return;
        end
        repeat (dly) @(negedge clk);
        @(posedge clk); #1;
        core_done = 1'b1; core_nack = nack; core_rx_data = rx;
        @(posedge clk);
        model_core_done(nack, rx);
        #1;
        core_done = 1'b0; core_nack = 1'b0;
        @(negedge clk);
        chk("enable low after core_done", 32'(enable), 32'h0);
        if (m_busy) begin
            @(negedge clk);
            chk("enable back after one cycle", 32'(enable), 32'h1);
        end
    endtask

    task automatic run_xfer(input int nack_idx, input logic [7:0] rx);
        int i = 0;
        while (m_busy && i < 10) begin
            core_respond(i == nack_idx, rx, $urandom_range(0, 3));
            i++;
        end
    endtask

    // Monitor: APB access-phase responses and each byte handed to the core.
    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        forever begin
            @(negedge clk);
            if (apb.psel && apb.penable) begin
                if (sb_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected APB access: no expectation queued");
                end else begin
                    d = sb_data.pop_front();
                    if (sb_chk.pop_front()) chk({sb_name[0], " prdata"}, apb.prdata, d);
                    chk({sb_name[0], " pslverr"}, 32'(apb.pslverr), 32'(sb_err.pop_front()));
                    void'(sb_name.pop_front());
                end
            end
            if (enable && !en_prev) begin
                chk("byte slave_address", 32'(slave_address), 32'(m_addr));
                chk("byte rw", 32'(rw), 32'(m_rw));
                if (!m_rw) begin
                    if (mq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL byte data_in: got 0x%0h with no byte expected", data_in);
                    end else begin
                        b = mq.pop_front();
                        chk("byte data_in", 32'(data_in), 32'(b));
                    end
                end
            end
            en_prev = enable;
        end
    end

    initial begin
        logic [4:0] ua [4];
        ua[0] = 5'h14; ua[1] = 5'h18; ua[2] = 5'h1C; ua[3] = 5'h02;

        rst = 1'b1;
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = '0; apb.pwdata = '0;
        core_done = 0; core_nack = 0; core_rx_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset enable", 32'(enable), 32'h0);
        chk("reset slave_address", 32'(slave_address), 32'h0);
        chk("reset data_in", 32'(data_in), 32'h0);
        chk("reset rw", 32'(rw), 32'h0);
        chk("reset prdata", apb.prdata, 32'h0);
        chk("reset pslverr", 32'(apb.pslverr), 32'h0);
        for (int i = 0; i < 5; i++) apb_read(5'(4 * i), "reset reg");

        // Two-byte write to 0x6B
        apb_write(5'(ADDR_OFF), 32'h6B, "addr");
        apb_write(5'(TXDATA_OFF), 32'hAA, "push AA");
        apb_write(5'(TXDATA_OFF), 32'h55, "push 55");
        apb_write(5'(CTRL_OFF), 32'h5, "start write");
        run_xfer(-1, 8'h00);
        apb_read(5'(STATUS_OFF), "status after write");
        apb_read(5'(CTRL_OFF), "ctrl after write");

        // Single-byte read
        apb_write(5'(CTRL_OFF), 32'h7, "start read");
        run_xfer(-1, 8'h3C);
        apb_read(5'(STATUS_OFF), "status rx valid");
        apb_read(5'(RXDATA_OFF), "rxdata");
        apb_read(5'(STATUS_OFF), "status rx cleared");

        // Overfill, then push/pop while transferring
        for (int i = 0; i < 5; i++) apb_write(5'(TXDATA_OFF), 32'(8'h10 + i), "push fill");
        apb_read(5'(STATUS_OFF), "status full");
        apb_write(5'(CTRL_OFF), 32'h5, "start drain");
        wait_en("drain first byte");
        apb_read(5'(STATUS_OFF), "status mid xfer");
        apb_write(5'(TXDATA_OFF), 32'h99, "push mid xfer");
        run_xfer(-1, 8'h00);
        apb_read(5'(STATUS_OFF), "status drained");

        // NACK on first of three bytes
        for (int i = 0; i < 3; i++) apb_write(5'(TXDATA_OFF), 32'(8'hC0 + i), "push nack");
        apb_write(5'(CTRL_OFF), 32'h5, "start nack");
        run_xfer(0, 8'h00);
        chk("enable after nack", 32'(enable), 32'h0);
        apb_read(5'(STATUS_OFF), "status nack");
        apb_write(5'(STATUS_OFF), 32'h110, "w1c nack/done");
        apb_read(5'(STATUS_OFF), "status nack cleared");

        // Abort by clearing EN mid-transfer
        apb_write(5'(TXDATA_OFF), 32'h21, "push abort");
        apb_write(5'(TXDATA_OFF), 32'h22, "push abort");
        apb_write(5'(CTRL_OFF), 32'h5, "start abort");
        wait_en("abort first byte");
        apb_write(5'(CTRL_OFF), 32'h0, "clear en");
        repeat (2) @(negedge clk);
        chk("enable after en abort", 32'(enable), 32'h0);
        apb_read(5'(STATUS_OFF), "status after en abort");

        // Reset mid-transfer
        apb_write(5'(TXDATA_OFF), 32'h31, "push rst");
        apb_write(5'(TXDATA_OFF), 32'h32, "push rst");
        apb_write(5'(CTRL_OFF), 32'h5, "start rst");
        wait_en("rst first byte");
        rst = 1'b1;
        #1;
        chk("enable async reset", 32'(enable), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        apb_read(5'(STATUS_OFF), "status after reset");
        apb_read(5'(CTRL_OFF), "ctrl after reset");

        // Randomised traffic
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 6))
                0: apb_write(5'(TXDATA_OFF), 32'($urandom_range(0, 255)), "rnd push");
                1: apb_write(5'(ADDR_OFF), $urandom, "rnd addr");
                2: apb_read(5'(4 * $urandom_range(0, 4)), "rnd read");
                3: begin
                    apb_write(5'(CTRL_OFF), ($urandom_range(0, 3) == 0) ? 32'h4 : 32'h5, "rnd start wr");
                    run_xfer(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, 8'h00);
                end
                4: begin
                    apb_write(5'(CTRL_OFF), 32'h7, "rnd start rd");
                    run_xfer(($urandom_range(0, 3) == 0) ? 0 : -1, 8'($urandom_range(0, 255)));
                end
                5: apb_write(5'(STATUS_OFF), $urandom & 32'h110, "rnd w1c");
                default: begin
                    if ($urandom_range(0, 1) == 1) apb_write(ua[$urandom_range(0, 3)], $urandom, "unmapped wr");
                    else apb_read(ua[$urandom_range(0, 3)], "unmapped rd");
                end
            endcase
        end
        for (int i = 0; i < 5; i++) apb_read(5'(4 * i), "final reg");

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(sb_data.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop guard so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
